// File: rtl/mips_alu_pkg.sv
// Shared definitions for the ALU and the multiply/divide sequencer:
// ALU select codes, operation encoding, sequencer state type and iteration count.
package mips_alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int ITER = 32;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_DIVU  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/ALU_32bits.sv
// Combinational 32-bit ALU: AND, OR, ADD, SUB and SLT with overflow and zero flags.
module ALU_32bits
    import mips_alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_ctl,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero
);

    logic        b_inv;
    logic [31:0] b_eff;
    logic [31:0] sum;

    // Bit 2 of the select turns the adder into a subtractor (SUB and SLT).
    assign b_inv    = alu_ctl[2];
    assign b_eff    = b_inv ? ~b : b;
    assign sum      = a + b_eff + {31'd0, b_inv};
    assign overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);

    always_comb begin
        result = 32'd0;
        case (alu_ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = sum;
            ALU_SUB: result = sum;
            ALU_SLT: result = {31'd0, sum[31] ^ overflow};
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle, with all
// add/subtract work time-shared through a single ALU_32bits instance.
module muldiv_sequencer
    import mips_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    state_e      state_reg;
    logic [4:0]  count_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] rs_reg;
    logic [31:0] rt_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        dbz_reg;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_zero;
    logic        unused_alu_flags;

    logic        mul_carry;
    logic        div_borrow;
    logic        div_ok;
    logic        last_iter;

    // DIV subtracts the divisor from the shifted partial remainder; MUL adds
    // the multiplicand (or zero) to hi.
    always_comb begin
        alu_a   = hi_reg;
        alu_b   = lo_reg[0] ? rs_reg : 32'd0;
        alu_ctl = ALU_ADD;
        if (state_reg == S_DIV) begin
            alu_a   = {hi_reg[30:0], lo_reg[31]};
            alu_b   = rt_reg;
            alu_ctl = ALU_SUB;
        end
    end

    ALU_32bits u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .alu_ctl  (alu_ctl),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero)
    );

    assign unused_alu_flags = alu_overflow ^ alu_zero;

    assign mul_carry  = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_result[31]);
    assign div_borrow = (~alu_a[31] & alu_b[31]) | ((~alu_a[31] | alu_b[31]) & alu_result[31]);
    assign div_ok     = hi_reg[31] | ~div_borrow;
    assign last_iter  = (count_reg == 5'(ITER - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            count_reg <= 5'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            rs_reg    <= 32'd0;
            rt_reg    <= 32'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        rs_reg    <= rs_val;
                        rt_reg    <= rt_val;
                        count_reg <= 5'd0;
                        dbz_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        if (op_e'(op) == OP_MULTU) begin
                            hi_reg    <= 32'd0;
                            lo_reg    <= rt_val;
                            state_reg <= S_MUL;
                        end else if (rt_val != 32'd0) begin
                            hi_reg    <= 32'd0;
                            lo_reg    <= rs_val;
                            state_reg <= S_DIV;
                        end else begin
                            hi_reg    <= rs_val;
                            lo_reg    <= '1;
                            dbz_reg   <= 1'b1;
                            state_reg <= S_FIN;
                        end
                    end
                end
                S_MUL: begin
                    hi_reg    <= {mul_carry, alu_result[31:1]};
                    lo_reg    <= {alu_result[0], lo_reg[31:1]};
                    count_reg <= count_reg + 5'd1;
                    if (last_iter) begin
                        count_reg <= 5'd0;
                        done_reg  <= 1'b1;
                        state_reg <= S_FIN;
                    end
                end
                S_DIV: begin
                    hi_reg    <= div_ok ? alu_result : {hi_reg[30:0], lo_reg[31]};
                    lo_reg    <= {lo_reg[30:0], div_ok};
                    count_reg <= count_reg + 5'd1;
                    if (last_iter) begin
                        count_reg <= 5'd0;
                        done_reg  <= 1'b1;
                        state_reg <= S_FIN;
                    end
                end
                S_FIN: begin
                    // Divide-by-zero arrives here with done low and raises it
                    // one cycle later; every other path arrives with done high.
                    if (done_reg) begin
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, hand-written corner
// sequences and random back-to-back traffic, all checked through a scoreboard.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    muldiv_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } sb_entry_t;

    int        checks     = 0;
    int        failures   = 0;
    int        cyc        = 0;
    int        done_count = 0;
    logic      prev_done  = 1'b0;
    sb_entry_t sb[$];
    sb_entry_t mon_e;
    vec_t      vecs[14];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!o) begin
            p = 64'(a) * 64'(b);
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
    endfunction

    // Compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            $display("done: hi=%h lo=%h dbz=%b cyc=%0d", hi, lo, div_by_zero, cyc);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                check("done_cycle", cyc, mon_e.cyc);
                check("busy_with_done", {31'd0, busy}, 32'd1);
            end
            check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        end
        prev_done = done;
    end

    // Called at a negedge; start is sampled by the following posedge.
    task automatic do_start(input logic o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        sb_entry_t e;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        e.hi   = ehi;
        e.lo   = elo;
        e.dbz  = edbz;
        e.cyc  = cyc + 1 + ((o && b == 32'd0) ? 1 : 32);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int dcyc, output bit ok);
        ok   = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (done) begin
                ok   = 1'b1;
                dcyc = cyc;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_64");
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                          output int dcyc, output bit ok);
        @(negedge clk);
        do_start(o, a, b, ehi, elo, edbz);
        wait_done(dcyc, ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          prev_d;
        int          dc_before;
        bit          ok;
        logic        o;
        logic [31:0] a;
        logic [31:0] b;
        logic [64:0] m;

        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0000, 32'd1,         32'd0,         32'h8000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};
        vecs[4]  = '{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{1'b0, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0};
        vecs[6]  = '{1'b0, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         1'b0};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF, 1'b0};
        vecs[10] = '{1'b1, 32'd3,         32'd10,        32'd3,         32'd0,         1'b0};
        vecs[11] = '{1'b1, 32'd1,         32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
        vecs[12] = '{1'b1, 32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[13] = '{1'b0, 32'd1,         32'd1,         32'd0,         32'd1,         1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        op     = 1'b0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);

        // First start in the cycle right after reset is released.
        reset = 1'b0;
        run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, d, ok);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, vecs[i].dbz, d, ok);

        // Results and div_by_zero hold in IDLE.
        run_op(1'b1, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, d, ok);
        repeat (4) @(negedge clk);
        check("idle_hold_busy", {31'd0, busy}, 32'd0);
        check("idle_hold_hi", hi, 32'd9);
        check("idle_hold_lo", lo, 32'hFFFF_FFFF);
        check("idle_hold_dbz", {31'd0, div_by_zero}, 32'd1);

        // Start pulsed at MUL iteration 10 must be ignored.
        dc_before = done_count;
        @(negedge clk);
        do_start(1'b0, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D, 32'hEADB_EEF0, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_mid_mul", {31'd0, busy}, 32'd1);
        start  = 1'b1;
        op     = 1'b1;
        rs_val = 32'd1000;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(d, ok);
        repeat (40) @(negedge clk);
        check("ignored_start_done_count", done_count - dc_before, 32'd1);

        // Reset at DIV iteration 10 aborts the operation.
        @(negedge clk);
        do_start(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        sb.delete();
        reset = 1'b0;
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, d, ok);

        // Random back-to-back traffic with a nonzero divisor.
        prev_d = 0;
        for (int i = 0; i < 10; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (o && (i % 2 == 1)) b = b >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            m = model(o, a, b);
            run_op(o, a, b, m[63:32], m[31:0], m[64], d, ok);
            if (ok && i > 0) check("done_spacing", d - prev_d, 32'd34);
            prev_d = d;
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
